// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage register family.
//   - default datapath sizing (XLEN, REGIDX_W, CTRL_W_DEFAULT)
//   - control bit indices within the ctrl field
//   - wb_payload_t: packed MEM/WB payload for the default sizing
//   - skid slice state encoding and main-register load source
package pipe_pkg;

  localparam int XLEN           = 64;
  localparam int REGIDX_W       = 5;
  localparam int CTRL_W_DEFAULT = 2;

  // Bit positions inside the ctrl field; bits above these pass through untouched.
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;

  typedef struct packed {
    logic [REGIDX_W-1:0]       rd;
    logic [XLEN-1:0]           alu;
    logic [XLEN-1:0]           rdata;
    logic [CTRL_W_DEFAULT-1:0] ctrl;
  } wb_payload_t;

  // Encoding is {skid_valid, main_valid}; 2'b10 (skid without main) is illegal.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD  = 2'd0,
    MAIN_INPUT = 2'd1,
    MAIN_SKID  = 2'd2
  } main_src_t;

  // Occupancy = main_valid + skid_valid.
  function automatic logic [1:0] occupancy(input skid_state_t s);
    return {1'b0, (s != ST_EMPTY)} + {1'b0, (s == ST_FULL)};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: valid/ready payload bus between two pipeline stages.
//   valid  producer has a payload this cycle
//   ready  consumer accepts this cycle
//   rd     destination register index (RD_W)
//   alu    ALU result (DATA_W)
//   rdata  memory read data (DATA_W)
//   ctrl   control bits (CTRL_W); bit 0 RegWrite, bit 1 MemtoReg
// Modports: master drives the payload and valid, slave drives ready.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int RD_W   = REGIDX_W,
  parameter int CTRL_W = CTRL_W_DEFAULT
);

  logic              valid;
  logic              ready;
  logic [RD_W-1:0]   rd;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] rdata;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid, rd, alu, rdata, ctrl,
    input  ready
  );

  modport slave (
    input  valid, rd, alu, rdata, ctrl,
    output ready
  );

endinterface

// File: rtl/pipe_skid_stage_slice.sv
// skid_reg_slice: generic W-bit, 2-entry valid/ready register slice.
// The main register drives the output; the skid register absorbs the one
// entry that can arrive while downstream stalls, so in_ready is a pure
// function of registered state and still allows one transfer per cycle.
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   flush            synchronous: empties the slice, drops any incoming entry
//   in_valid/ready   upstream handshake (in_ready registered)
//   in_data          upstream payload
//   out_valid/ready  downstream handshake
//   out_data         main register contents
//   count            occupancy 0..2
module skid_reg_slice
  import pipe_pkg::*;
#(
  parameter int W              = 8,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  skid_state_t  state_q, state_d;
  main_src_t    main_src;
  logic         skid_load;
  logic         wipe;
  logic         acc, emt;
  logic [W-1:0] main_q, skid_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign acc       = in_valid & in_ready;
  assign emt       = out_valid & out_ready;
  assign count     = occupancy(state_q);
  assign out_data  = main_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    main_src  = MAIN_HOLD;
    skid_load = 1'b0;
    wipe      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      wipe    = CLEAR_ON_FLUSH;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d  = ST_ONE;
            main_src = MAIN_INPUT;
          end
        end
        ST_ONE: begin
          if (acc && !emt) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (acc && emt) begin
            // Simultaneous accept and emit: main is replaced in place.
            main_src = MAIN_INPUT;
          end else if (emt) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the emit side can move.
          if (emt) begin
            state_d  = ST_ONE;
            main_src = MAIN_SKID;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: the payload registers are reset as well, not only the valid state,
  // so the output pins are deterministic from reset onward even when the
  // bubble masking is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (wipe) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_src == MAIN_INPUT)     main_q <= in_data;
      else if (main_src == MAIN_SKID) main_q <= skid_q;
      if (skid_load) skid_q <= in_data;
    end
  end

`ifndef SYNTHESIS
  // The unused 2'b10 encoding would mean a skid entry with an empty main.
  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (reset)
    state_q inside {ST_EMPTY, ST_ONE, ST_FULL}
  );
`endif

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: parametrised pipeline stage register (MEM/WB successor).
// Carries {rd, alu, rdata, ctrl} through a 2-entry skid slice with a
// registered in_ready and 1-cycle latency. Bubbles never carry control bits,
// so a stale RegWrite cannot reach writeback.
//   clk       rising-edge clock
//   reset     asynchronous, active-high
//   flush     synchronous kill of held and incoming entries
//   in_bus    slave side: upstream valid/ready + payload
//   out_bus   master side: downstream valid/ready + payload
//   count     occupancy 0..2
// CLEAR_ON_BUBBLE=1 forces out_rd/out_alu/out_rdata to 0 while out_valid=0
// and clears the payload registers on flush; with 0 they hold their last value.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W          = XLEN,
  parameter int RD_W            = REGIDX_W,
  parameter int CTRL_W          = CTRL_W_DEFAULT,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_skid_stage_if.slave   in_bus,
  pipe_skid_stage_if.master  out_bus,
  output logic [1:0]         count
);

  localparam int W = RD_W + 2 * DATA_W + CTRL_W;

  logic [W-1:0]      in_flat, main_flat;
  logic              main_valid;
  logic [RD_W-1:0]   main_rd;
  logic [DATA_W-1:0] main_alu, main_rdata;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_flat = {in_bus.rd, in_bus.alu, in_bus.rdata, in_bus.ctrl};

  skid_reg_slice #(
    .W              (W),
    .CLEAR_ON_FLUSH (CLEAR_ON_BUBBLE)
  ) u_slice (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_bus.valid),
    .in_ready  (in_bus.ready),
    .in_data   (in_flat),
    .out_valid (main_valid),
    .out_ready (out_bus.ready),
    .out_data  (main_flat),
    .count     (count)
  );

  assign {main_rd, main_alu, main_rdata, main_ctrl} = main_flat;

  // Control is always gated; data is gated only when bubbles must read zero.
  assign out_bus.valid = main_valid;
  assign out_bus.ctrl  = main_valid ? main_ctrl : '0;
  assign out_bus.rd    = (main_valid || !CLEAR_ON_BUBBLE) ? main_rd    : '0;
  assign out_bus.alu   = (main_valid || !CLEAR_ON_BUBBLE) ? main_alu   : '0;
  assign out_bus.rdata = (main_valid || !CLEAR_ON_BUBBLE) ? main_rdata : '0;

`ifndef SYNTHESIS
  // Upstream must hold valid and payload while it is being back-pressured.
  a_upstream_stable: assert property (
    @(posedge clk) disable iff (reset)
    (in_bus.valid && !in_bus.ready && !flush) |=> (in_bus.valid && $stable(in_flat))
  );

  a_count_range: assert property (
    @(posedge clk) disable iff (reset) count != 2'd3
  );

  if (CTRL_W > CTRL_MEMTOREG) begin : g_ctrl_chk
    a_no_spurious_regwrite: assert property (
      @(negedge clk) disable iff (reset)
      out_bus.ctrl[CTRL_REGWRITE] |-> out_bus.valid
    );
    a_no_spurious_memtoreg: assert property (
      @(negedge clk) disable iff (reset)
      out_bus.ctrl[CTRL_MEMTOREG] |-> out_bus.valid
    );
  end
`endif

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline stage register, successor to the fixed-width MEM/WB latch. It carries a payload (ALU result, load data, rd, control bits) between any two pipeline stages using a valid/ready handshake. A 2-entry skid buffer lets upstream see a registered ready with no throughput loss. Synchronous flush inserts bubbles. Control bits are forced to zero on bubbles, so a spurious RegWrite never reaches writeback.

Parameters:
DATA_W, 64, width of each data field (ALU result and read data)
RD_W, 5, destination register index width
CTRL_W, 2, control bit count; bit 0 = RegWrite, bit 1 = MemtoReg, higher bits are opaque pass-through
CLEAR_ON_BUBBLE, 1, when 1, data/rd outputs read 0 while out_valid=0; when 0, they hold their last value

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream has a payload this cycle
in_ready  output  1  stage can accept; registered, depends only on state
in_rd  input  RD_W  destination register
in_alu  input  DATA_W  ALU result
in_rdata  input  DATA_W  memory read data
in_ctrl  input  CTRL_W  control bits
flush  input  1  synchronous kill of all held and incoming entries
out_valid  output  1  payload present at output
out_ready  input  1  downstream accepts this cycle
out_rd  output  RD_W
out_alu  output  DATA_W
out_rdata  output  DATA_W
out_ctrl  output  CTRL_W  all zeros whenever out_valid=0
count  output  2  occupancy, 0..2

Behaviour:
- Reset (asynchronous, active-high):
  - main_valid=0, skid_valid=0, count=0, in_ready=1, out_valid=0.
  - All payload registers are cleared to 0.
  - Reset may assert in any cycle. The entry in flight is lost, and no output transfer completes in that cycle.
- Storage: main register drives the outputs; skid register holds overflow. The skid is occupied only when main is occupied.
- Accept: acc = in_valid & in_ready. Emit: emt = out_valid & out_ready.
- in_ready = ~skid_valid (registered). Upstream never sees a combinational path from out_ready.
- State (main_valid, skid_valid) = EMPTY(0,0), ONE(1,0), FULL(1,1). Transitions with flush=0:
  - EMPTY: acc -> ONE, payload loaded into main.
  - ONE, acc & ~emt -> FULL, payload loaded into skid.
  - ONE, acc & emt -> ONE, main reloaded from the input (simultaneous accept and emit, full throughput).
  - ONE, ~acc & emt -> EMPTY.
  - FULL: emt -> ONE, main loaded from skid. No accept is possible in FULL because in_ready=0.
  - Otherwise: hold.
- Latency: 1 cycle, input accepted at edge N is visible at the output after edge N. Sustained throughput is 1 per cycle while out_ready=1.
- Ordering is strictly FIFO, with at most 2 entries.
- Flush (synchronous, priority over everything):
  - Next state = EMPTY and acc is discarded.
  - An emt occurring in the flush cycle still counts as delivered downstream; the stage takes no further action on it.
  - Payload regs are cleared if CLEAR_ON_BUBBLE=1.
- Output gating:
  - out_ctrl = main_valid ? main_ctrl : 0.
  - With CLEAR_ON_BUBBLE=1, out_rd, out_alu and out_rdata are also 0 when out_valid=0.
- count = main_valid + skid_valid.
- Payload widths pass through unchanged; no arithmetic is performed.
- Assertions (sim only):
  - skid_valid implies main_valid.
  - Inputs must stay stable while in_valid & ~in_ready. This is a protocol check on upstream.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_REGWRITE=0 and CTRL_MEMTOREG=1 bit indices.
  - Default XLEN=64 and REGIDX_W=5.
  - Packed typedef wb_payload_t {rd, alu, rdata, ctrl} for the default sizing.
- Natural sub-module: skid_reg_slice, a generic width-W 2-entry valid/ready slice with flush. The top instantiates it on the concatenated payload and adds ctrl gating and CLEAR_ON_BUBBLE masking.

Test Plan:
- Reset mid-stream with count=2 and out_valid=1 -> same cycle out_valid=0, out_ctrl=0, count=0, in_ready=1. After release, the first accept appears one cycle later.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with alu=0x10..0x17 and rd=1..8 -> outputs 0x10..0x17 in order, one per cycle, 1-cycle latency, count stays 1.
- Backpressure: out_ready=0 while pushing alu=0xA, then 0xB -> count=2 and in_ready=0 on the next cycle. Raising out_ready then emits 0xA, then 0xB, with no loss or duplication.
- Flush at count=2 (ctrl=2'b11) with in_valid=1 in the same cycle -> next cycle out_valid=0, out_ctrl=2'b00, count=0, and the incoming entry never appears.
- Bubble gating: in_valid=0 with in_ctrl=2'b01 and rd=5 held on the inputs -> out_ctrl=0. With CLEAR_ON_BUBBLE=1, out_rd=0 and out_alu=0.
- Parameter sweep: DATA_W=32, RD_W=6, CTRL_W=4 with random valid/ready at 50% -> scoreboard shows in-order, lossless delivery over 10k transactions and no assertion fires.
